bram_readback_streamer: RTL and testbench

Bulk-readback stage between the block-RAM array and the UART transmitter. One start pulse makes it read a run of consecutive 16-bit words from one EBR, then serialize each word MSB byte first to the transmitter, honouring its busy flag. After the run it appends an XOR checksum byte. This lets the controller dump a whole EBR without a per-word command round-trip.

---
 rtl/bram_readback_streamer.sv | 139 +++++++++++++
 tb/tb_bram_readback_streamer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_readback_streamer.sv
// Streams a run of 16-bit words from one EBR to the UART transmitter, MSB byte first,
// and closes the run with an XOR checksum byte.
//
// state  | meaning
// IDLE   | waiting for start
// RD     | read strobe for the current address
// CAP    | capture BRAM data, fold into checksum, advance address
// TX_HI  | launch word[15:8] once the transmitter is free
// G_HI   | guard cycle while transmitter busy rises
// TX_LO  | launch word[7:0] once the transmitter is free
// G_LO   | guard cycle, then next word or checksum
// TX_SUM | launch checksum byte once the transmitter is free
// G_SUM  | guard cycle after checksum launch
// FIN    | one-cycle done pulse
module bram_readback_streamer #(
  parameter int MEM_SELECT_BITS = 4,
  parameter int ADDR_BITS       = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       abort,
  input  logic [MEM_SELECT_BITS-1:0] start_select,
  input  logic [ADDR_BITS-1:0]       start_addr,
  input  logic [ADDR_BITS:0]         word_count,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [MEM_SELECT_BITS-1:0] mem_select,
  output logic [ADDR_BITS-1:0]       mem_addr,
  input  logic [15:0]                mem_data,
  output logic                       uart_tx_en,
  output logic [7:0]                 uart_tx_data,
  input  logic                       uart_tx_busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_RD, S_CAP, S_TX_HI, S_G_HI, S_TX_LO, S_G_LO, S_TX_SUM, S_G_SUM, S_FIN
  } state_t;

  state_t                     state_q, state_d;
  logic [MEM_SELECT_BITS-1:0] sel_q, sel_d;
  logic [ADDR_BITS-1:0]       addr_q, addr_d;
  logic [ADDR_BITS:0]         remaining_q, remaining_d;
  logic [15:0]                word_q, word_d;
  logic [7:0]                 csum_q, csum_d;
  logic                       launch;
  logic [7:0]                 tx_byte;
  logic                       live;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
      word_q      <= '0;
      csum_q      <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    word_d      = word_q;
    csum_d      = csum_q;
    launch      = 1'b0;
    tx_byte     = 8'h00;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sel_d       = start_select;
            addr_d      = start_addr;
            remaining_d = word_count;
            csum_d      = 8'h00;
            state_d     = (word_count != '0) ? S_RD : S_TX_SUM;
          end
        end
        S_RD:  state_d = S_CAP;
        S_CAP: begin
          word_d      = mem_data;
          csum_d      = csum_q ^ mem_data[15:8] ^ mem_data[7:0];
          addr_d      = addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          state_d     = S_TX_HI;
        end
        S_TX_HI: begin
          tx_byte = word_q[15:8];
          if (!uart_tx_busy) begin
            launch  = 1'b1;
            state_d = S_G_HI;
          end
        end
        S_G_HI: state_d = S_TX_LO;
        S_TX_LO: begin
          tx_byte = word_q[7:0];
          if (!uart_tx_busy) begin
            launch  = 1'b1;
            state_d = S_G_LO;
          end
        end
        S_G_LO: state_d = (remaining_q != '0) ? S_RD : S_TX_SUM;
        S_TX_SUM: begin
          tx_byte = csum_q;
          if (!uart_tx_busy) begin
            launch  = 1'b1;
            state_d = S_G_SUM;
          end
        end
        S_G_SUM: state_d = S_FIN;
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Strobes are suppressed immediately when the run is being cancelled or reset.
  assign live         = resetn && !abort;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_FIN) && live;
  assign rd_en        = (state_q == S_RD) && live;
  assign uart_tx_en   = launch && live;
  assign uart_tx_data = tx_byte;
  assign mem_select   = sel_q;
  assign mem_addr     = addr_q;

endmodule

// File: tb/tb_bram_readback_streamer.sv
// Scoreboard bench for bram_readback_streamer: BRAM and UART models, expected reads and
// bytes queued at start, compared as the design strobes them.
module tb_bram_readback_streamer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [3:0]  start_select = '0;
  logic [7:0]  start_addr = '0;
  logic [8:0]  word_count = '0;
  logic        busy, done, rd_en, uart_tx_en;
  logic [3:0]  mem_select;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;

  bram_readback_streamer dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .start_select(start_select), .start_addr(start_addr), .word_count(word_count),
    .busy(busy), .done(done), .rd_en(rd_en), .mem_select(mem_select),
    .mem_addr(mem_addr), .mem_data(mem_data), .uart_tx_en(uart_tx_en),
    .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16][256];
  int          tx_hold = 0;
  bit          force_busy = 1'b0;
  int          busy_cnt;

  initial busy_cnt = 0;
  initial mem_data = '0;

  // One-cycle BRAM; transmitter goes busy for tx_hold cycles after each launch.
  always @(posedge clk) begin
    if (rd_en) mem_data <= mem[mem_select][mem_addr];
    if (uart_tx_en && tx_hold > 0) busy_cnt <= tx_hold;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_busy = force_busy || (busy_cnt != 0);

  logic [7:0]  byte_q[$];
  logic [11:0] rd_q[$];
  int n_vec = 0, n_miss = 0;
  int tx_count = 0, rd_count = 0, done_cnt = 0, cyc = 0, last_en = 0;
  bit done_prev = 1'b0;
  logic [7:0]  mon_b;
  logic [11:0] mon_rd;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rd_en || uart_tx_en) check_val("rd_tx_exclusive", {31'd0, rd_en & uart_tx_en}, 0);
    if (rd_en) begin
      rd_count++;
      check_val("rd_expected", rd_q.size() > 0, 1);
      if (rd_q.size() > 0) begin
        mon_rd = rd_q.pop_front();
        check_val("rd_sel_addr", {mem_select, mem_addr}, mon_rd);
      end
    end
    if (uart_tx_en) begin
      tx_count++;
      last_en = cyc;
      check_val("tx_expected", byte_q.size() > 0, 1);
      if (byte_q.size() > 0) begin
        mon_b = byte_q.pop_front();
        check_val("tx_byte", uart_tx_data, mon_b);
      end
    end
    if (done) begin
      done_cnt++;
      check_val("done_width", done_prev, 0);
      check_val("done_after_sum_en", cyc - last_en, 2);
    end
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expect(input logic [3:0] sel, input logic [7:0] addr, input int count);
    logic [7:0]  cs;
    logic [7:0]  a;
    logic [15:0] w;
    cs = 8'h00;
    for (int i = 0; i < count; i++) begin
      a = addr + i[7:0];
      rd_q.push_back({sel, a});
      w = mem[sel][a];
      byte_q.push_back(w[15:8]);
      byte_q.push_back(w[7:0]);
      cs = cs ^ w[15:8] ^ w[7:0];
    end
    byte_q.push_back(cs);
  endtask

  task automatic pulse_start(input logic [3:0] sel, input logic [7:0] addr, input int count);
    start_select = sel;
    start_addr   = addr;
    word_count   = count[8:0];
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    check_val("done_seen", done_cnt - d0, 1);
    check_val("busy_after_done", busy, 0);
    check_val("sb_bytes_drained", byte_q.size(), 0);
    check_val("sb_reads_drained", rd_q.size(), 0);
    byte_q.delete();
    rd_q.delete();
    repeat (3) tick();
    check_val("done_once", done_cnt - d0, 1);
  endtask

  task automatic check_zero_outputs();
    check_val("zero_busy", busy, 0);
    check_val("zero_done", done, 0);
    check_val("zero_rd_en", rd_en, 0);
    check_val("zero_tx_en", uart_tx_en, 0);
    check_val("zero_mem_select", mem_select, 0);
    check_val("zero_mem_addr", mem_addr, 0);
    check_val("zero_tx_data", uart_tx_data, 0);
  endtask

  initial begin
    int tc, rc, d0, en_seen, changes;
    logic [7:0] d_hold;
    for (int s = 0; s < 16; s++)
      for (int a = 0; a < 256; a++) mem[s][a] = 16'($urandom);

    repeat (3) tick();
    check_zero_outputs();
    resetn = 1'b1;
    tick();

    // single word, transmitter never busy
    mem[3][8'h10] = 16'hA55A;
    tx_hold = 0;
    push_expect(4'd3, 8'h10, 1);
    pulse_start(4'd3, 8'h10, 1);
    check_val("t1_busy_n1", busy, 1);
    check_val("t1_rd_en_n1", rd_en, 1);
    check_val("t1_addr_n1", mem_addr, 8'h10);
    tick();
    tick();
    check_val("t1_first_en_n3", uart_tx_en, 1);
    check_val("t1_first_byte", uart_tx_data, 8'hA5);
    wait_done(50);

    // address wrap inside one EBR
    mem[2][8'hFF] = 16'h1234;
    mem[2][8'h00] = 16'hABCD;
    tx_hold = 2;
    push_expect(4'd2, 8'hFF, 2);
    pulse_start(4'd2, 8'hFF, 2);
    wait_done(200);

    // zero count sends only the 0x00 checksum
    rc = rd_count;
    tc = tx_count;
    byte_q.push_back(8'h00);
    pulse_start(4'd4, 8'h33, 0);
    check_val("t3_busy", busy, 1);
    check_val("t3_no_rd", rd_en, 0);
    wait_done(50);
    check_val("t3_rd_count", rd_count - rc, 0);
    check_val("t3_tx_count", tx_count - tc, 1);

    // backpressure held in TX_HI, then a full 256-word dump
    tx_hold = 3;
    force_busy = 1'b1;
    push_expect(4'd5, 8'h80, 256);
    pulse_start(4'd5, 8'h80, 256);
    tick();
    tick();
    d_hold = uart_tx_data;
    en_seen = 0;
    changes = 0;
    repeat (500) begin
      if (uart_tx_en) en_seen++;
      if (uart_tx_data !== d_hold) changes++;
      tick();
    end
    check_val("bp_no_en", en_seen, 0);
    check_val("bp_data_stable", changes, 0);
    check_val("bp_data_value", d_hold, {24'd0, mem[5][8'h80][15:8]});
    tc = tx_count;
    force_busy = 1'b0;
    tick();
    tick();
    check_val("bp_release_one_en", tx_count - tc, 1);
    wait_done(6000);

    // abort in TX_LO of word 3 of 8
    tx_hold = 10;
    for (int i = 0; i < 3; i++) rd_q.push_back({4'd6, 8'h20 + 8'(i)});
    byte_q.push_back(mem[6][8'h20][15:8]);
    byte_q.push_back(mem[6][8'h20][7:0]);
    byte_q.push_back(mem[6][8'h21][15:8]);
    byte_q.push_back(mem[6][8'h21][7:0]);
    byte_q.push_back(mem[6][8'h22][15:8]);
    d0 = done_cnt;
    tc = tx_count;
    pulse_start(4'd6, 8'h20, 8);
    for (int i = 0; i < 500 && (tx_count - tc) < 5; i++) tick();
    check_val("ab_reached_word3", tx_count - tc, 5);
    tick();
    check_val("ab_in_tx_lo_busy", busy, 1);
    check_val("ab_in_tx_lo_no_en", uart_tx_en, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("ab_idle_next", busy, 0);
    tc = tx_count;
    repeat (40) tick();
    check_val("ab_no_more_en", tx_count - tc, 0);
    check_val("ab_no_done", done_cnt - d0, 0);
    check_val("ab_bytes_used", byte_q.size(), 0);
    check_val("ab_reads_used", rd_q.size(), 0);
    byte_q.delete();
    rd_q.delete();
    tx_hold = 1;
    push_expect(4'd6, 8'h20, 8);
    pulse_start(4'd6, 8'h20, 8);
    wait_done(500);

    // start pulses during a dump are ignored
    tx_hold = 1;
    push_expect(4'd7, 8'h40, 4);
    pulse_start(4'd7, 8'h40, 4);
    repeat (3) begin
      tick();
      pulse_start(4'd9, 8'h00, 50);
    end
    wait_done(300);

    // reset in the middle of a dump
    tx_hold = 2;
    push_expect(4'd8, 8'h90, 8);
    pulse_start(4'd8, 8'h90, 8);
    repeat (12) tick();
    resetn = 1'b0;
    byte_q.delete();
    rd_q.delete();
    tick();
    check_zero_outputs();
    tc = tx_count;
    repeat (2) tick();
    resetn = 1'b1;
    repeat (20) tick();
    check_val("rst_no_en_after", tx_count - tc, 0);
    check_val("rst_idle_after", busy, 0);

    // dump after reset, wrapping through address 0
    tx_hold = 0;
    push_expect(4'd1, 8'hF0, 20);
    pulse_start(4'd1, 8'hF0, 20);
    wait_done(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
